button_event_queue: RTL and testbench
=====================================

# button_event_queue

Serialises the debounced, one-pulsed push-button strobes into an ordered stream of button IDs for the game controller FSM. It sits directly downstream of the per-button debounce/one-pulse stage, one strobe input per button. Simultaneous presses are kept, never lost silently, and are buffered in a small FIFO. The controller pops them with a valid/ready handshake at its own pace.

## Interface
- `N_BTN`, default 4: number of button strobe inputs (2..16).
- `DEPTH`, default 8: FIFO entries; must be a power of two (2..64).
- `ID_W`, default clog2(N_BTN): width of a button ID.
- `CNT_W`, default clog2(DEPTH)+1: width of the occupancy count.

Ports:
- `clk`  in  1: single system clock. One clock only.
- `rst_n`  in  1: synchronous, active-low reset.
- `pulse_in`  in  N_BTN: one-cycle press strobes; bit i = button i.
- `clear`  in  1: synchronous flush (round restart).
- `ev_valid`  out  1: head entry available.
- `ev_id`  out  ID_W: button ID at FIFO head; 0 when empty.
- `ev_ready`  in  1: consumer accepts the head entry.
- `count`  out  CNT_W: current FIFO occupancy.
- `overflow`  out  1: sticky; at least one press was dropped.

## Operation
- **Pending stage.** `pending[N_BTN-1:0]` is registered.
  - Each cycle: `pending <= (pending | pulse_in) & ~grant`.
  - `grant` is the one-hot lowest set bit of `pending`. It is issued only when `push_ok = (count < DEPTH) || pop`.
- **Encoding.** A granted bit index is written as `ev_id` into the FIFO at `wr_ptr`.
- **Pop.** `pop = ev_valid && ev_ready`. `rd_ptr` advances and `count` decrements.
- **Simultaneous push and pop.** `count` is unchanged. This is legal when full; the pop frees the slot written.
- **Pointers.** `rd_ptr`/`wr_ptr` are clog2(DEPTH) bits and wrap naturally. `count` disambiguates full from empty.
- **Ordering.**
  - Presses in different cycles leave the FIFO in arrival order, as far as the pending stage allows.
  - Presses in the same cycle leave lowest index first.
- **Drop rule.** If `pulse_in[i]` is high while `pending[i]` is already set and bit i is not granted that cycle:
  - The new press merges into the existing pending bit.
  - `overflow` sets.
- **Full FIFO.** While the FIFO is full with no pop, `pending` holds. Further strobes on already-pending buttons trigger the drop rule.
- **Flush.** `clear` zeroes the FIFO pointers, `count`, `pending` and `overflow`.
  - `clear` has priority over `pulse_in`, push and pop in the same cycle. Those strobes are discarded.
- **`overflow`.** Cleared only by `rst_n` or `clear`.
- **`ev_id` when empty.** `ev_id` is forced to 0 whenever `ev_valid` = 0.

## Timing
- **Reset.** On a clock edge with `rst_n` = 0, all state clears:
  - Outputs: `ev_valid`=0, `ev_id`=0, `count`=0, `overflow`=0.
  - Internal: `pending`=0, pointers=0.
- **Latency.** With an empty FIFO and no other pending bits:
  - A strobe sampled at edge t sets `pending` at t.
  - It is pushed at edge t+1.
  - `ev_valid` is high in the cycle after edge t+1, i.e. 2 cycles from strobe to visible event.
- **Throughput.** At most one push and one pop per cycle. K simultaneous presses drain into the FIFO over K consecutive cycles.
- **Outputs.** `ev_valid`, `ev_id` and `count` are derived from registered state only; there is no combinational path from `ev_ready`.
- **Push decision.** `push_ok` depends combinationally on `ev_ready`. This is accepted because the path is internal.
- **Handshake.** `ev_id` is stable while `ev_valid`=1 and `ev_ready`=0.

## Structure
- **Shared package `brainwars_pkg`.** Holds:
  - `clog2` function.
  - `N_BTN_DEFAULT`.
  - Button ID constants: `BTN_UP`=0, `BTN_DOWN`=1, `BTN_LEFT`=2, `BTN_RIGHT`=3.
- **Sub-module `sync_fifo`.**
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: `clk`, `rst_n`, `clr`, `push`, `din`, `pop`, `dout`, `count`, `full`, `empty`.
  - Show-ahead read.
- **Top level.** Holds the pending register, the lowest-index grant, the encoder and the overflow logic.

## Test plan
- **Single press.** Reset, then `pulse_in`=0001 for one cycle: `ev_valid` rises 2 cycles later with `ev_id`=0, and `count`=1. `ev_ready`=1 for one cycle: `count`=0 and `ev_valid`=0.
- **Simultaneous presses.** `pulse_in`=1011 in one cycle with `ev_ready`=0: `count` reaches 3 after 3 push cycles. Popping then returns IDs 0, 1, 3 in order; `overflow`=0.
- **Full FIFO with concurrent pop.** Fill 8 entries with `ev_ready` held 0, then strobe button 2: `pending[2]` holds and `count`=8. Assert `ev_ready` for one cycle: push and pop occur together, `count` stays 8, and the tail entry = 2.
- **Drop and overflow.** With the FIFO full and `pending[1]` set, strobe button 1 again: `overflow` goes to 1 next cycle and stays 1 through subsequent pops.
- **Flush priority.** Assert `clear` in the same cycle as `pulse_in`=1111 and `ev_ready`=1 while `count`=5: next cycle `count`=0, `ev_valid`=0, `pending`=0 and `overflow`=0, with no events afterwards.
- **Reset mid-operation.** Drive `rst_n`=0 for one edge while `count`=4 and `pending`≠0: all outputs read 0. The next single press behaves exactly as in the first scenario.

Source files
------------

// File: rtl/brainwars_pkg.sv
// brainwars_pkg: shared constants and helpers for the button input path.
package brainwars_pkg;
    localparam int N_BTN_DEFAULT = 4;
    localparam int BTN_UP = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_LEFT = 2;
    localparam int BTN_RIGHT = 3;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/button_event_queue_if.sv
// button_event_queue_if: strobe inputs and event handshake of the button queue.
interface button_event_queue_if
    import brainwars_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEFAULT,
    parameter int DEPTH = 8,
    parameter int ID_W = clog2(N_BTN),
    parameter int CNT_W = clog2(DEPTH) + 1
);
    logic [N_BTN-1:0] pulse_in;
    logic clear;
    logic ev_valid;
    logic [ID_W-1:0] ev_id;
    logic ev_ready;
    logic [CNT_W-1:0] count;
    logic overflow;
    modport master (
        input pulse_in, clear, ev_ready,
        output ev_valid, ev_id, count, overflow
    );
    modport slave (
        output pulse_in, clear, ev_ready,
        input ev_valid, ev_id, count, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; count separates full from empty.
module sync_fifo
    import brainwars_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int CNT_W = clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic push,
    input  logic [WIDTH-1:0] din,
    input  logic pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic full,
    output logic empty
);
    localparam int AW = clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    always_ff @(posedge clk) if (rst_n && !clr && push) mem[wr_ptr] <= din;
    assign dout = mem[rd_ptr];
    assign full = count == CNT_W'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/button_event_queue.sv
// button_event_queue: pending bits per button, lowest-index grant into an ordered FIFO of IDs.
module button_event_queue
    import brainwars_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEFAULT,
    parameter int DEPTH = 8,
    parameter int ID_W = clog2(N_BTN),
    parameter int CNT_W = clog2(DEPTH) + 1
) (
    input logic clk,
    input logic rst_n,
    button_event_queue_if.master bus
);
    logic [N_BTN-1:0] pending, grant;
    logic [ID_W-1:0] id, dout;
    logic push, pop, push_ok, full, empty;
    always_comb begin
        id = '0;
        for (int i = N_BTN - 1; i >= 0; i--) if (pending[i]) id = ID_W'(i);
    end
    assign pop = !empty && bus.ev_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok = !full || pop;
    assign grant = push_ok ? pending & (~pending + N_BTN'(1)) : '0;
    assign push = |grant;
    sync_fifo #(.WIDTH(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .clr(bus.clear),
        .push(push),
        .din(id),
        .pop(pop),
        .dout(dout),
        .count(bus.count),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            pending <= '0;
            bus.overflow <= 1'b0;
        end else begin
            pending <= (pending | bus.pulse_in) & ~grant;
            if (|(bus.pulse_in & pending & ~grant)) bus.overflow <= 1'b1;
        end
    end
    assign bus.ev_valid = !empty;
    assign bus.ev_id = empty ? '0 : dout;
endmodule

// File: tb/tb_button_event_queue.sv
// tb_button_event_queue: directed scenarios plus random traffic against a queue-based model.
module tb_button_event_queue;
    import brainwars_pkg::*;
    localparam int N = 4;
    localparam int D = 8;
    logic clk = 0;
    logic rst_n = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int q[$];
    bit [3:0] mp;
    bit mov;
    always #5 clk = ~clk;
    button_event_queue_if #(.N_BTN(N), .DEPTH(D)) bus ();
    button_event_queue #(.N_BTN(N), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    function automatic logic [11:0] exp_vec();
        logic [1:0] id;
        id = q.size() > 0 ? 2'(q[0]) : 2'd0;
        return {q.size() > 0, id, 4'(q.size()), mov, mp};
    endfunction
    wire [11:0] obs_vec = {bus.ev_valid, bus.ev_id, bus.count, bus.overflow, dut.pending};

    task automatic model_step(input logic [3:0] p, input logic c, input logic r);
        bit pm;
        int g, t;
        if (c) begin
            q.delete();
            mp = 0;
            mov = 0;
            return;
        end
        pm = q.size() > 0 && r;
        g = -1;
        if (q.size() < D || pm) for (int i = N - 1; i >= 0; i--) if (mp[i]) g = i;
        for (int i = 0; i < N; i++) if (p[i] && mp[i] && i != g) mov = 1;
        if (pm) t = q.pop_front();
        if (g >= 0) begin
            q.push_back(g);
            mp[g] = 0;
        end
        for (int i = 0; i < N; i++) if (p[i] && i != g) mp[i] = 1;
    endtask

    task automatic tick(input logic [3:0] p, input logic c, input logic r);
        bus.pulse_in = p;
        bus.clear = c;
        bus.ev_ready = r;
        @(posedge clk);
        model_step(p, c, r);
        #1;
        bus.pulse_in = 0;
        bus.clear = 0;
        bus.ev_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.pulse_in = 0;
        bus.clear = 0;
        bus.ev_ready = 0;
        @(posedge clk);
        q.delete();
        mp = 0;
        mov = 0;
        #1;
        rst_n = 1;
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) tick(4'(1 << (k % N)), 0, 0);
        tick(0, 0, 0);
    endtask

    task automatic test_reset();
        bus.pulse_in = 4'hf;
        bus.clear = 0;
        bus.ev_ready = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        mp = 0;
        mov = 0;
        n_cmp++;
        if (obs_vec !== 12'h000) begin
            n_bad++;
            $display("FAIL reset: got %h expected 000", obs_vec);
        end
        rst_n = 1;
        bus.pulse_in = 0;
        bus.ev_ready = 0;
        tick(0, 0, 0);
    endtask

    task automatic test_single_press();
        tick(4'b0001, 0, 0);
        n_cmp++;
        if (dut.pending !== 4'b0001 || bus.ev_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pending: got pend=%b valid=%b expected 0001/0", dut.pending, bus.ev_valid);
        end
        tick(0, 0, 0);
        n_cmp++;
        if (bus.ev_valid !== 1'b1 || bus.ev_id !== 2'(BTN_UP) || bus.count !== 4'd1) begin
            n_bad++;
            $display("FAIL single_visible: got v=%b id=%0d cnt=%0d expected 1/0/1", bus.ev_valid, bus.ev_id, bus.count);
        end
        tick(0, 0, 1);
        n_cmp++;
        if (obs_vec !== 12'h000) begin
            n_bad++;
            $display("FAIL single_pop: got %h expected 000", obs_vec);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] ids [3];
        ids[0] = 2'(BTN_UP);
        ids[1] = 2'(BTN_DOWN);
        ids[2] = 2'(BTN_RIGHT);
        do_reset();
        tick(4'b1011, 0, 0);
        repeat (3) tick(0, 0, 0);
        n_cmp++;
        if (bus.count !== 4'd3 || obs_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL simul_count: got cnt=%0d vec=%h expected 3 vec=%h", bus.count, obs_vec, exp_vec());
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (bus.ev_valid !== 1'b1 || bus.ev_id !== ids[k]) begin
                n_bad++;
                $display("FAIL simul_order%0d: got v=%b id=%0d expected 1/%0d", k, bus.ev_valid, bus.ev_id, ids[k]);
            end
            tick(0, 0, 1);
        end
        n_cmp++;
        if (bus.overflow !== 1'b0 || bus.ev_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_end: got ovf=%b v=%b expected 0/0", bus.overflow, bus.ev_valid);
        end
    endtask

    task automatic test_full_concurrent();
        logic [1:0] last;
        do_reset();
        fill(D);
        tick(4'b0100, 0, 0);
        tick(0, 0, 0);
        n_cmp++;
        if (dut.pending !== 4'b0100 || bus.count !== 4'd8) begin
            n_bad++;
            $display("FAIL full_hold: got pend=%b cnt=%0d expected 0100/8", dut.pending, bus.count);
        end
        tick(0, 0, 1);
        n_cmp++;
        if (bus.count !== 4'd8 || dut.pending !== 4'b0000) begin
            n_bad++;
            $display("FAIL full_pushpop: got cnt=%0d pend=%b expected 8/0000", bus.count, dut.pending);
        end
        last = 0;
        for (int k = 0; k < D; k++) begin
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL full_drain%0d: got %h expected %h", k, obs_vec, exp_vec());
            end
            last = bus.ev_id;
            tick(0, 0, 1);
        end
        n_cmp++;
        if (last !== 2'(BTN_LEFT) || bus.ev_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL full_tail: got id=%0d v=%b expected 2/0", last, bus.ev_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fill(D);
        tick(4'b0010, 0, 0);
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_early: got %b expected 0", bus.overflow);
        end
        tick(4'b0010, 0, 0);
        n_cmp++;
        if (bus.overflow !== 1'b1 || dut.pending !== 4'b0010) begin
            n_bad++;
            $display("FAIL ovf_set: got ovf=%b pend=%b expected 1/0010", bus.overflow, dut.pending);
        end
        for (int k = 0; k < 10; k++) tick(0, 0, 1);
        n_cmp++;
        if (bus.overflow !== 1'b1 || obs_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL ovf_sticky: got %h expected %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_flush();
        do_reset();
        tick(4'b0011, 0, 0);
        tick(4'b0010, 0, 0);
        tick(4'b0100, 0, 0);
        tick(4'b1000, 0, 0);
        tick(4'b0001, 0, 0);
        tick(0, 0, 0);
        n_cmp++;
        if (bus.count !== 4'd5 || bus.overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_pre: got cnt=%0d ovf=%b expected 5/1", bus.count, bus.overflow);
        end
        tick(4'b1111, 1, 1);
        n_cmp++;
        if (obs_vec !== 12'h000) begin
            n_bad++;
            $display("FAIL flush: got %h expected 000", obs_vec);
        end
        repeat (4) tick(0, 0, 1);
        n_cmp++;
        if (obs_vec !== 12'h000) begin
            n_bad++;
            $display("FAIL flush_quiet: got %h expected 000", obs_vec);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(4'b1111, 0, 0);
        repeat (2) tick(0, 0, 0);
        tick(4'b0001, 0, 0);
        n_cmp++;
        if (bus.count !== 4'd3 || dut.pending !== 4'b1001) begin
            n_bad++;
            $display("FAIL mid_pre: got cnt=%0d pend=%b expected 3/1001", bus.count, dut.pending);
        end
        tick(0, 0, 0);
        n_cmp++;
        if (bus.count !== 4'd4 || dut.pending === 4'b0000) begin
            n_bad++;
            $display("FAIL mid_pre2: got cnt=%0d pend=%b expected 4/nonzero", bus.count, dut.pending);
        end
        do_reset();
        n_cmp++;
        if (obs_vec !== 12'h000) begin
            n_bad++;
            $display("FAIL mid_reset: got %h expected 000", obs_vec);
        end
        test_single_press();
    endtask

    task automatic test_random();
        logic [3:0] p;
        logic c, r;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            p = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            c = $urandom_range(0, 99) == 0;
            r = $urandom_range(0, 99) < ((k % 200) < 100 ? 15 : 75);
            tick(p, c, r);
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random%0d: got %h expected %h", k, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        bus.pulse_in = 0;
        bus.clear = 0;
        bus.ev_ready = 0;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_full_concurrent();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
